fc_layer_seq: RTL

- Parametrised fully-connected layer for the VAE datapath: out[j] = sat(relu?((sum_i w[j][i]*x[i] + b[j]<<FRAC) >>> FRAC)).
- Time-multiplexed across PAR MAC lanes; reads weights from an external synchronous ROM/BRAM.
- start/busy/done handshake lets encoder and decoder layers be chained.
- Next generation of the per-neuron parallel layer: adds fixed-point rescale, saturation, optional ReLU, lane sharing and a clean one-shot run.

---
 rtl/fc_pkg.sv | 33 +++
 rtl/fc_mac_lane.sv | 52 +++++
 rtl/fc_layer_seq.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/fc_pkg.sv
// Shared definitions for the sequential fully-connected layer: FSM encoding,
// Q-format default and the integer helpers used to size and clamp the datapath.
package fc_pkg;

  localparam int FRAC_DEF = 6;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_WB    = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Never returns less than 1 so that derived counters keep a real bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One signed multiply-accumulate lane with the write-back rescale, optional
// ReLU and saturation applied combinationally to the current accumulator.
module fc_mac_lane
  import fc_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int FRAC  = FRAC_DEF,
  parameter int ACC_W = 31
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    acc_en,
  input  logic signed [WIDTH-1:0] w,
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] bias,
  input  logic                    relu_en,
  output logic        [WIDTH-1:0] y,
  output logic                    sat_o
);

  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   sum;
  logic signed [ACC_W-1:0]   r;
  logic signed [63:0]        r_wide;
  logic signed [63:0]        r_sat;

  always_comb begin
    prod  = w * x;
    acc_d = acc_q;
    if (clr) acc_d = '0;
    else if (acc_en) acc_d = acc_q + ACC_W'(prod);
  end

  // Bias is aligned to the product scale before the single rescale shift.
  always_comb begin
    sum = acc_q + (ACC_W'(bias) <<< FRAC);
    r   = sum >>> FRAC;
    if (relu_en && (r < 0)) r = '0;
    r_wide = 64'(r);
    r_sat  = saturate(r_wide, WIDTH);
    y      = r_sat[WIDTH-1:0];
    sat_o  = (r_sat != r_wide);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

endmodule

// File: rtl/fc_layer_seq.sv
// Fully-connected layer time-multiplexed over PAR MAC lanes, one neuron group
// per pass over the inputs, with weights streamed from a 1-cycle-latency ROM.
module fc_layer_seq
  import fc_pkg::*;
#(
  parameter int IN_N  = 200,
  parameter int OUT_N = 10,
  parameter int WIDTH = 11,
  parameter int FRAC  = FRAC_DEF,
  parameter int PAR   = 2,
  localparam int NG    = OUT_N / PAR,
  localparam int AW    = clog2(NG * IN_N),
  localparam int ACC_W = 2 * WIDTH + clog2(IN_N) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     relu_en,
  input  logic [IN_N*WIDTH-1:0]    x_in,
  input  logic [OUT_N*WIDTH-1:0]   bias_in,
  output logic [AW-1:0]            w_addr,
  output logic                     w_rd,
  input  logic [PAR*WIDTH-1:0]     w_data,
  output logic [OUT_N*WIDTH-1:0]   y_out,
  output logic                     busy,
  output logic                     done,
  output logic                     sat,
  output logic [2:0]               dbg_state
);

  localparam int GW = clog2(NG);
  localparam int IW = clog2(IN_N);

  state_e                 state_q, state_d;
  logic [GW-1:0]          g_q, g_d;
  logic [IW-1:0]          i_q, i_d;
  logic [IW-1:0]          xi_q, xi_d;
  logic                   pend_q, pend_d;
  logic                   relu_q, relu_d;
  logic                   sat_q, sat_d;
  logic [OUT_N*WIDTH-1:0] y_q, y_d;

  logic [WIDTH-1:0]       x_cur;
  logic [WIDTH-1:0]       lane_bias [PAR];
  logic [WIDTH-1:0]       lane_y    [PAR];
  logic [PAR-1:0]         lane_sat;
  logic                   lane_clr;

  // Handshake: start is a level sampled only in IDLE; busy covers RUN..WB and
  // done is a one-cycle pulse with busy already low, so start during done is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      g_q     <= '0;
      i_q     <= '0;
      xi_q    <= '0;
      pend_q  <= 1'b0;
      relu_q  <= 1'b0;
      sat_q   <= 1'b0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      i_q     <= i_d;
      xi_q    <= xi_d;
      pend_q  <= pend_d;
      relu_q  <= relu_d;
      sat_q   <= sat_d;
      y_q     <= y_d;
    end
  end

  // pend/xi delay the read strobe and index by one cycle to meet returning data.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    i_d     = i_q;
    relu_d  = relu_q;
    sat_d   = sat_q;
    y_d     = y_q;
    pend_d  = (state_q == S_RUN);
    xi_d    = i_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          g_d     = '0;
          i_d     = '0;
          relu_d  = relu_en;
          sat_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (i_q == IW'(IN_N - 1)) begin
          i_d     = '0;
          state_d = S_DRAIN;
        end else begin
          i_d = i_q + IW'(1);
        end
      end
      S_DRAIN: state_d = S_WB;
      S_WB: begin
        for (int l = 0; l < PAR; l++) begin
          y_d[(int'(g_q) * PAR + l) * WIDTH +: WIDTH] = lane_y[l];
        end
        if (|lane_sat) sat_d = 1'b1;
        if (g_q == GW'(NG - 1)) begin
          state_d = S_DONE;
        end else begin
          g_d     = g_q + GW'(1);
          state_d = S_RUN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == S_RUN) || (state_q == S_DRAIN) || (state_q == S_WB);
    done      = (state_q == S_DONE);
    w_rd      = (state_q == S_RUN);
    w_addr    = w_rd ? AW'(int'(g_q) * IN_N + int'(i_q)) : '0;
    lane_clr  = (state_q == S_WB);
    dbg_state = state_q;
    y_out     = y_q;
    sat       = sat_q;
    x_cur     = x_in[int'(xi_q) * WIDTH +: WIDTH];
    for (int l = 0; l < PAR; l++) begin
      lane_bias[l] = bias_in[(int'(g_q) * PAR + l) * WIDTH +: WIDTH];
    end
  end

  for (genvar l = 0; l < PAR; l++) begin : g_lane
    fc_mac_lane #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (lane_clr),
      .acc_en  (pend_q),
      .w       (w_data[l*WIDTH +: WIDTH]),
      .x       (x_cur),
      .bias    (lane_bias[l]),
      .relu_en (relu_q),
      .y       (lane_y[l]),
      .sat_o   (lane_sat[l])
    );
  end

endmodule
